// File: rtl/fetch_ctrl_pkg.sv
// Shared constants and state encoding for the instruction-fetch controller.
package fetch_ctrl_pkg;

    // PC loaded by reset and the inclusive bounds of the legal fetch window.
    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam logic [31:0] PC_MIN   = 32'h0000_3000;
    localparam logic [31:0] PC_MAX   = 32'h0000_6FFC;

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_HOLD  = 2'b01,
        ST_ERR   = 2'b10
    } fetch_state_t;

endpackage : fetch_ctrl_pkg

// File: rtl/fetch_ctrl_if.sv
// Bundle of the fetch controller's pipeline, memory and status signals.
// master: the fetch controller itself; slave: the surrounding pipeline/memory.
interface fetch_ctrl_if;

    logic        stall;
    logic [31:0] npc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] F_pc;
    logic [31:0] F_instr;
    logic        F_valid;
    logic        pc_err;
    logic [31:0] fetch_cnt;

    modport master (
        input  stall,
        input  npc,
        input  imem_ready,
        input  imem_rdata,
        output imem_req,
        output imem_addr,
        output F_pc,
        output F_instr,
        output F_valid,
        output pc_err,
        output fetch_cnt
    );

    modport slave (
        output stall,
        output npc,
        output imem_ready,
        output imem_rdata,
        input  imem_req,
        input  imem_addr,
        input  F_pc,
        input  F_instr,
        input  F_valid,
        input  pc_err,
        input  fetch_cnt
    );

endinterface : fetch_ctrl_if

// File: rtl/fetch_ctrl_pc_check.sv
// Next-PC legality check: word aligned and inside the fetch window.
module pc_check
    import fetch_ctrl_pkg::*;
(
    input  logic [31:0] pc,
    output logic        legal
);

    logic w_aligned;
    logic w_in_range;

    assign w_aligned  = (pc[1:0] == 2'b00);
    assign w_in_range = (pc >= PC_MIN) && (pc <= PC_MAX);
    assign legal      = w_aligned && w_in_range;

endmodule : pc_check

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller feeding the F/D pipeline register.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_FETCH | request outstanding at F_pc; a ready word is offered directly
// ST_HOLD  | word arrived while stalled; offered from the hold buffer
// ST_ERR   | illegal next PC seen on acceptance; frozen until reset
//
// imem_req and F_valid depend only on state and imem_ready, never on npc,
// so the next-PC unit cannot close a loop through the request/valid path.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    fetch_ctrl_if.master bus
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;

    logic [31:0] r_f_pc;
    logic [31:0] w_f_pc_nxt;
    logic [31:0] r_hold;
    logic [31:0] w_hold_nxt;
    logic [31:0] r_fetch_cnt;
    logic [31:0] w_fetch_cnt_nxt;
    logic        r_pc_err;
    logic        w_pc_err_nxt;

    logic        w_req;
    logic        w_valid;
    logic [31:0] w_instr;
    logic        w_accept;
    logic        w_npc_legal;

    pc_check u_pc_check (
        .pc    (bus.npc),
        .legal (w_npc_legal)
    );

    // Per-state memory request and the word offered to the F/D register.
    always_comb begin
        w_req   = 1'b0;
        w_valid = 1'b0;
        w_instr = r_hold;
        unique case (r_state)
            ST_FETCH: begin
                w_req   = 1'b1;
                w_valid = bus.imem_ready;
                w_instr = bus.imem_rdata;
            end
            ST_HOLD: begin
                w_valid = 1'b1;
            end
            default: begin
                w_valid = 1'b0;
            end
        endcase
        w_accept = w_valid & ~bus.stall;
    end

    // Next-state, PC advance, hold-buffer capture and acceptance bookkeeping.
    always_comb begin
        w_state_nxt     = r_state;
        w_f_pc_nxt      = r_f_pc;
        w_hold_nxt      = r_hold;
        w_fetch_cnt_nxt = r_fetch_cnt;
        w_pc_err_nxt    = r_pc_err;

        unique case (r_state)
            ST_FETCH: begin
                // A word that arrives under stall must be parked, since the
                // memory is free to change imem_rdata once the request drops.
                if (bus.imem_ready && bus.stall) begin
                    w_hold_nxt  = bus.imem_rdata;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                w_state_nxt = ST_HOLD;
            end
            ST_ERR: begin
                w_state_nxt  = ST_ERR;
                w_pc_err_nxt = 1'b1;
            end
            default: begin
                // Unused encoding: park in the error state rather than guess.
                w_state_nxt  = ST_ERR;
                w_pc_err_nxt = 1'b1;
            end
        endcase

        if (w_accept) begin
            // The accepted instruction counts even when its successor is bad.
            w_fetch_cnt_nxt = r_fetch_cnt + 32'd1;
            if (w_npc_legal) begin
                w_f_pc_nxt  = bus.npc;
                w_state_nxt = ST_FETCH;
            end else begin
                w_pc_err_nxt = 1'b1;
                w_state_nxt  = ST_ERR;
            end
        end
    end

    // State and datapath registers; reset wins over any same-cycle event.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_FETCH;
            r_f_pc      <= PC_RESET;
            r_hold      <= 32'h0000_0000;
            r_fetch_cnt <= 32'h0000_0000;
            r_pc_err    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_f_pc      <= w_f_pc_nxt;
            r_hold      <= w_hold_nxt;
            r_fetch_cnt <= w_fetch_cnt_nxt;
            r_pc_err    <= w_pc_err_nxt;
        end
    end

    assign bus.imem_req  = w_req;
    assign bus.imem_addr = r_f_pc;
    assign bus.F_pc      = r_f_pc;
    assign bus.F_instr   = w_instr;
    assign bus.F_valid   = w_valid;
    assign bus.pc_err    = r_pc_err;
    assign bus.fetch_cnt = r_fetch_cnt;

endmodule : fetch_ctrl
